// File: rtl/shift_pkg.sv
// Shared types and constants for the multi-cycle shift sequencer.
package shift_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-position shifter; the vacated bit takes the supplied fill value.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] data,
    input  dir_e             dir,
    input  logic             fill,
    output logic [WIDTH-1:0] data_o
);

    always_comb begin
        if (dir == DIR_RIGHT) begin
            data_o = {fill, data[WIDTH-1:1]};
        end else begin
            data_o = {data[WIDTH-2:0], fill};
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: one shift step per clock, valid/ready on both sides.
// Optional rotate mode (extra in_rot port) is enabled by defining SHIFT_ROTATE_EN.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [CNT_W-1:0] in_amt,
    input  logic             in_dir,
`ifdef SHIFT_ROTATE_EN
    input  logic             in_rot,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             busy
);

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    dir_e             r_dir;
    dir_e             w_dir_next;
    logic [WIDTH-1:0] w_step;
    logic             w_fill;

`ifdef SHIFT_ROTATE_EN
    logic r_rot;
    logic w_rot_next;

    // Rotate feeds the bit leaving one end back into the other end.
    assign w_fill = r_rot & ((r_dir == DIR_LEFT) ? r_data[WIDTH-1] : r_data[0]);
`else
    assign w_fill = 1'b0;
`endif

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .data   (r_data),
        .dir    (r_dir),
        .fill   (w_fill),
        .data_o (w_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_cnt   <= '0;
            r_dir   <= DIR_LEFT;
`ifdef SHIFT_ROTATE_EN
            r_rot   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_data  <= w_data_next;
            r_cnt   <= w_cnt_next;
            r_dir   <= w_dir_next;
`ifdef SHIFT_ROTATE_EN
            r_rot   <= w_rot_next;
`endif
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_data_next  = r_data;
        w_cnt_next   = r_cnt;
        w_dir_next   = r_dir;
`ifdef SHIFT_ROTATE_EN
        w_rot_next   = r_rot;
`endif
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_data_next  = in_a;
                    w_cnt_next   = in_amt;
                    w_dir_next   = dir_e'(in_dir);
`ifdef SHIFT_ROTATE_EN
                    w_rot_next   = in_rot;
`endif
                    w_state_next = (in_amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                w_data_next = w_step;
                w_cnt_next  = r_cnt - CNT_W'(1);
                // The last step is taken on the cycle the counter reads one.
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign in_ready   = rst_n && (r_state == IDLE);
    assign out_valid  = (r_state == DONE);
    assign busy       = (r_state == SHIFT) || (r_state == DONE);
    assign out_result = r_data;

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle barrel-shift controller for the ALU. Performs an N-position shift by applying a single-bit shift step once per clock.
- Accepts one operand, shift amount and direction over a valid/ready input handshake. Returns the result over a valid/ready output handshake.
- Sits between the ALU operation decoder and the result mux. Replaces direct use of the combinational one-bit shifters for multi-bit shifts.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, $clog2(WIDTH), shift-amount and counter width (5 for WIDTH=32).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request (high only in IDLE).
- in_a  input  WIDTH  operand to shift.
- in_amt  input  CNT_W  shift amount, 0..WIDTH-1.
- in_dir  input  1  0 = left (toward MSB), 1 = right (toward LSB).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_result  output  WIDTH  shifted operand.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE; data_q=0; cnt_q=0; dir_q=0. Outputs: out_valid=0, out_result=0, busy=0, in_ready=0 while rst_n is low, in_ready=1 in IDLE after reset release.
- FSM has three states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch in_a into data_q, in_amt into cnt_q, in_dir into dir_q.
  - Next state is DONE if in_amt==0, else SHIFT.
  - Without in_valid, stay in IDLE and hold registers.
- SHIFT:
  - Each cycle, data_q <= one-step shift of data_q in direction dir_q. Vacated bit is filled with 0.
  - cnt_q <= cnt_q-1. When cnt_q==1, next state is DONE.
  - in_ready=0. in_valid is ignored.
- DONE:
  - out_valid=1 and out_result=data_q.
  - On out_ready, next state is IDLE and out_valid drops the following cycle.
  - While out_ready=0, hold data_q and out_valid stable indefinitely.
- Latency: request accepted at edge t gives out_valid high from cycle t+1+in_amt (amt=0 gives t+1; amt=31 gives t+32).
- Throughput: one op per in_amt+2 cycles minimum. There is no overlap: a new request cannot be accepted in the same cycle as an output handshake.
- out_result is valid only while out_valid=1, but it is always driven from data_q (no X).
- in_amt is CNT_W wide, so WIDTH or larger cannot be expressed. No saturation logic is required.
- Asynchronous reset mid-SHIFT or mid-DONE aborts the operation immediately. The result is lost and no out_valid pulse is produced.
- Both handshake sides are registered-state driven. There are no combinational paths from in_valid to out_valid, or from out_ready to in_ready.

Optional Feature:
- Macro: SHIFT_ROTATE_EN.
- Defined:
  - An extra input port in_rot (1 bit) is latched with the request.
  - When in_rot=1, the vacated bit is filled with the bit shifted out (rotate). Left rotate fills bit0 with the old MSB; right rotate fills the MSB with the old bit0.
  - When in_rot=0, behaviour is identical to the undefined case.
- Undefined: port in_rot is absent and fill is always 0.

Decomposition:
- Package shift_pkg holds:
  - WIDTH default constant.
  - dir_e enum: DIR_LEFT=1'b0, DIR_RIGHT=1'b1.
  - state_e enum: IDLE, SHIFT, DONE (2-bit encoding).
- Sub-module shift_step:
  - Purely combinational one-position shifter with inputs data[WIDTH-1:0], dir, fill; output data_o.
  - Left: data_o={data[WIDTH-2:0],fill}. Right: data_o={fill,data[WIDTH-1:1]}.
  - The sequencer instantiates exactly one shift_step and computes fill locally (0, or rotate bit under SHIFT_ROTATE_EN).

Test Plan:
- Left shift: in_a=0x0000_0001, amt=4, dir=0, out_ready=1, accept at t -> out_valid at t+5, out_result=0x0000_0010; in_ready back high at t+6.
- Right extremes: in_a=0x8000_0000, amt=31, dir=1 -> out_result=0x0000_0001 at t+32. Also in_a=0xFFFF_FFFF, amt=8, dir=1 -> 0x00FF_FFFF.
- Zero amount: in_a=0xDEAD_BEEF, amt=0 -> out_valid at t+1, out_result=0xDEAD_BEEF unchanged.
- Backpressure: amt=2, out_ready held low 6 cycles after out_valid -> out_result and out_valid stable throughout, in_ready=0 and in_valid ignored, single handshake when out_ready rises.
- Reset mid-operation: amt=20, assert rst_n=0 at t+7 -> out_valid=0, busy=0, out_result=0 immediately; after release in_ready=1 and the next request completes normally.
- Rotate (SHIFT_ROTATE_EN): in_a=0x8000_0001, amt=1, dir=0, in_rot=1 -> 0x0000_0003; in_rot=0 or macro undefined -> 0x0000_0002.
